// File: rtl/byte_serializer_if.sv
// Load/ready handshake and serial output bundle for byte_serializer.
// master drives data/load; slave (the serializer) returns ready and the serial stream.
interface byte_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  modport master (
    output data, load,
    input  ready, serial_out, serial_valid, busy, done
  );

  modport slave (
    input  data, load,
    output ready, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial frame transmitter; optional even parity bit when PARITY_EN is defined.
// Latency: first bit the cycle after accept, done after the last bit, ready the cycle after done.
// Backpressure: ready only in IDLE; load while not ready is dropped, never queued.
module byte_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  byte_serializer_if.slave bus
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int CCW = $clog2(BIT_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] CYC_LAST = CCW'(BIT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [CCW-1:0]   cyc_cnt;
  logic             bit_end;
  logic             shift_bit;
  logic             in_parity;
  logic             parity_out;

`ifdef PARITY_EN
  logic             parity_q;
`endif

  assign bit_end   = (cyc_cnt == CYC_LAST);
  assign shift_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            state   <= SHIFT;
            shreg   <= bus.data;
            bit_cnt <= '0;
            cyc_cnt <= '0;
`ifdef PARITY_EN
            parity_q <= ^bus.data;
`endif
          end
        end

        SHIFT: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            shreg   <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef PARITY_EN
              state   <= PARITY;
`else
              state   <= DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_EN
  assign in_parity  = (state == PARITY);
  assign parity_out = in_parity & parity_q;
`else
  assign in_parity  = 1'b0;
  assign parity_out = 1'b0;
`endif

  // Outputs decode straight from state so reset values appear the cycle after reset.
  assign bus.ready        = (state == IDLE);
  assign bus.busy         = (state == SHIFT) | in_parity;
  assign bus.serial_valid = (state == SHIFT) | in_parity;
  assign bus.done         = (state == DONE);
  assign bus.serial_out   = ((state == SHIFT) & shift_bit) | parity_out;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: two instances (LSB-first 1 clk/bit, MSB-first 3 clk/bit)
// checked cycle by cycle against an expected bit stream built from the frame rules.
module tb_byte_serializer;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  byte_serializer_if #(.WIDTH(8)) ifa ();
  byte_serializer_if #(.WIDTH(8)) ifb ();

  byte_serializer #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  byte_serializer #(.WIDTH(8), .BIT_CYCLES(3), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // {ready, serial_out, serial_valid, busy, done}
  logic [4:0] obs_a, obs_b;
  assign obs_a = {ifa.ready, ifa.serial_out, ifa.serial_valid, ifa.busy, ifa.done};
  assign obs_b = {ifb.ready, ifb.serial_out, ifb.serial_valid, ifb.busy, ifb.done};

  function automatic logic [4:0] obs(input bit sel);
    return sel ? obs_b : obs_a;
  endfunction

  task automatic drive(input bit sel, input logic ld, input logic [7:0] d);
    if (sel) begin ifb.load = ld; ifb.data = d; end
    else     begin ifa.load = ld; ifa.data = d; end
  endtask

  // Sends one frame starting in a ready cycle; returns #1 after the edge that makes ready reappear.
  task automatic run_frame(input bit sel, input logic [7:0] d, input bit mid_load, input string tag);
    int         bc;
    bit         lsb;
    logic       q[$];
    logic [4:0] exp;
    bc  = sel ? 3 : 1;
    lsb = !sel;
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < bc; r++) q.push_back(lsb ? d[i] : d[7-i]);
`ifdef PARITY_EN
    for (int r = 0; r < bc; r++) q.push_back(^d);
`endif
    exp = 5'b10000;
    vectors++;
    if (obs(sel) !== exp) begin
      miscompares++;
      $display("FAIL %s ready_before_load got=%b want=%b", tag, obs(sel), exp);
    end
    drive(sel, 1'b1, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~d);
    foreach (q[k]) begin
      exp = {1'b0, q[k], 3'b110};
      vectors++;
      if (obs(sel) !== exp) begin
        miscompares++;
        $display("FAIL %s bit_cycle%0d data=%h got=%b want=%b", tag, k, d, obs(sel), exp);
      end
      if (mid_load && k == 2) drive(sel, 1'b1, 8'hFF);
      else                    drive(sel, 1'b0, 8'($urandom));
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 8'($urandom));
    exp = 5'b00001;
    vectors++;
    if (obs(sel) !== exp) begin
      miscompares++;
      $display("FAIL %s done_cycle data=%h got=%b want=%b", tag, d, obs(sel), exp);
    end
    @(posedge clk); #1;
    exp = 5'b10000;
    vectors++;
    if (obs(sel) !== exp) begin
      miscompares++;
      $display("FAIL %s ready_after_done data=%h got=%b want=%b", tag, d, obs(sel), exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 8'h81);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs_a !== 5'b10000 || obs_b !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_held got_a=%b got_b=%b want=10000", obs_a, obs_b);
    end
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (obs_a !== 5'b10000 || obs_b !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_release got_a=%b got_b=%b want=10000", obs_a, obs_b);
    end
  endtask

  task automatic test_lsb_first();
    run_frame(1'b0, 8'hA5, 1'b0, "lsb_a5");
  endtask

  task automatic test_msb_slow();
    run_frame(1'b1, 8'h81, 1'b0, "msb_81");
  endtask

  task automatic test_ignored_load();
    run_frame(1'b0, 8'h0F, 1'b1, "ignore_lsb");
    run_frame(1'b1, 8'h0F, 1'b1, "ignore_msb");
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic [4:0] exp;
    d = 8'h3C;
    drive(1'b0, 1'b1, d);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      exp = {1'b0, d[k], 3'b110};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL abort_bit%0d got=%b want=%b", k, obs_a, exp);
      end
      if (k == 3) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    vectors++;
    if (obs_a !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort_reset_values got=%b want=10000", obs_a);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs_a !== 5'b10000) begin
        miscompares++;
        $display("FAIL abort_stays_idle cycle%0d got=%b want=10000", c, obs_a);
      end
    end
  endtask

  task automatic test_parity();
    run_frame(1'b0, 8'h07, 1'b0, "parity_07");
    run_frame(1'b0, 8'h03, 1'b0, "parity_03");
    run_frame(1'b1, 8'h07, 1'b0, "parity_07_msb");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      bit sel;
      sel = 1'($urandom_range(0, 1));
      run_frame(sel, 8'($urandom), 1'b0, "random_b2b");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_slow();
    test_ignored_load();
    test_abort();
    test_parity();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
